// File: rtl/conf_int_mac_dot_prod_seq.sv
// conf_int_mac_dot_prod_seq
// Sequencer for a combinational (flop-less) MAC. It streams operand pairs into the
// MAC and feeds the registered accumulator back as c_in. When all pairs have been
// accumulated it returns the dot product. The accumulator here is the only state on
// the MAC path.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, len          begin a dot product of len pairs (sampled only in IDLE)
//   in_valid/in_ready   operand pair handshake, in_a/in_b operands
//   mac_a/mac_b         operands to MAC (wired straight from in_a/in_b)
//   mac_c_in            accumulator to MAC
//   mac_d               MAC result (mac_a*mac_b + mac_c_in)
//   res_valid/res_ready result handshake, res_data dot product, res_ovf sticky wrap
//   busy                sequencer not idle
module conf_int_mac_dot_prod_seq #(
  parameter int unsigned OP_BITWIDTH        = 16,
  parameter int unsigned DATA_PATH_BITWIDTH = 16,
  parameter int unsigned LEN_BITWIDTH       = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LEN_BITWIDTH-1:0]           len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0]     in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0]     in_b,
  output logic [DATA_PATH_BITWIDTH-1:0]     mac_a,
  output logic [DATA_PATH_BITWIDTH-1:0]     mac_b,
  output logic [2*DATA_PATH_BITWIDTH-1:0]   mac_c_in,
  input  logic [2*DATA_PATH_BITWIDTH-1:0]   mac_d,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [2*DATA_PATH_BITWIDTH-1:0]   res_data,
  output logic                              res_ovf,
  output logic                              busy
);

  localparam int unsigned DW = DATA_PATH_BITWIDTH;
  localparam int unsigned AW = 2 * DW;
  localparam int unsigned LW = LEN_BITWIDTH;

  // The MAC operator width belongs to the MAC instance. This marker block is
  // elaborated only when the MAC would be narrower than the operands routed to it.
  if (OP_BITWIDTH < DATA_PATH_BITWIDTH) begin : g_op_width_below_data_width
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [AW-1:0]  acc;
  logic [LW-1:0]  cnt;
  logic           ovf;
  logic           xfer;

  // Operands pass straight through; the accumulator closes the MAC loop.
  assign mac_a    = in_a;
  assign mac_b    = in_b;
  assign mac_c_in = acc;
  assign res_data = acc;
  assign res_ovf  = ovf;

  assign xfer = in_valid && in_ready;

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            ovf  <= 1'b0;
            busy <= 1'b1;
            if (len != '0) begin
              cnt      <= len;
              in_ready <= 1'b1;
              state    <= ACCUM;
            end else begin
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        ACCUM: begin
          if (xfer) begin
            acc <= mac_d;
            cnt <= cnt - LW'(1);
            // Each product fits in AW bits, so a wrap shows as the sum dropping below acc.
            ovf <= ovf | (mac_d < acc);
            if (cnt == LW'(1)) begin
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conf_int_mac_dot_prod_seq.sv
// Testbench for conf_int_mac_dot_prod_seq: a driver issues dot-product operations and
// queues expected results; a monitor compares each presented result.
module tb_conf_int_mac_dot_prod_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_c_in;
  logic [31:0] mac_d;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_ovf;
  logic        busy;

  conf_int_mac_dot_prod_seq #(
    .OP_BITWIDTH(16),
    .DATA_PATH_BITWIDTH(16),
    .LEN_BITWIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c_in(mac_c_in), .mac_d(mac_d),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .busy(busy)
  );

  // The combinational MAC that sits next to the sequencer.
  assign mac_d = 32'(mac_a) * 32'(mac_b) + mac_c_in;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vcyc_q[$];

  logic [15:0] va [0:255];
  logic [15:0] vb [0:255];

  bit force_low = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic abort_run(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench aborted");
  endtask

  // Consumer: randomly back-pressures results unless a test holds it low.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      res_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks results, stability while held and handshake behaviour.
  exp_t held;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (prev_valid && prev_ready)
          check("valid_drop_after_handshake", 64'(res_valid), 64'd0);
        if (res_valid && !prev_valid) begin
          if (exp_q.size() == 0 || vcyc_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
            held.data = res_data;
            held.ovf  = res_ovf;
          end else begin
            int ecyc;
            held = exp_q.pop_front();
            ecyc = vcyc_q.pop_front();
            check("result_latency", 64'(cyc), 64'(ecyc));
            check("res_data", 64'(res_data), 64'(held.data));
            check("res_ovf", 64'(res_ovf), 64'(held.ovf));
          end
        end else if (res_valid && prev_valid) begin
          check("res_data_stable", 64'(res_data), 64'(held.data));
          check("res_ovf_stable", 64'(res_ovf), 64'(held.ovf));
        end
        if (res_valid)
          check("in_ready_low_in_done", 64'(in_ready), 64'd0);
        prev_valid = res_valid;
        prev_ready = res_ready;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy) begin
      t++;
      if (t > 500) abort_run("wait_idle");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // Expected result from plain unbounded arithmetic over the operand vectors.
  task automatic push_expected(input int n);
    longint unsigned sum = 0;
    exp_t e;
    for (int i = 0; i < n; i++)
      sum += longint'(va[i]) * longint'(vb[i]);
    e.data = sum[31:0];
    e.ovf  = (sum >> 32) != 0;
    exp_q.push_back(e);
  endtask

  // Feeds pair i and returns after the edge that accepted it.
  task automatic feed_pair(input int i, input int n);
    int  t = 0;
    bit  ok = 1'b0;
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = va[i];
    in_b     = vb[i];
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      if (ok && i == n - 1) vcyc_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      t++;
      if (!ok && t > 100) abort_run("pair_accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input int n, input int gmin, input int gmax, input bit hold_done);
    push_expected(n);
    wait_idle();
    start = 1'b1;
    len   = 8'(n);
    if (n == 0) vcyc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    len   = 8'($urandom);
    if (n == 0) begin
      @(negedge clk);
      check("len0_in_ready", 64'(in_ready), 64'd0);
      check("len0_busy", 64'(busy), 64'd1);
    end else begin
      for (int i = 0; i < n; i++) begin
        int g = $urandom_range(gmin, gmax);
        repeat (g) begin
          in_valid = 1'b0;
          start    = 1'($urandom_range(0, 1));
          len      = 8'($urandom);
          @(posedge clk);
          #1;
        end
        feed_pair(i, n);
      end
    end
    if (hold_done) begin
      force_low = 1'b1;
      repeat (5) begin
        start = 1'b1;
        len   = 8'($urandom_range(1, 255));
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      check("hold_done_busy", 64'(busy), 64'd1);
      force_low = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_ovf", 64'(res_ovf), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three pairs back-to-back, then with two-cycle gaps
    va[0] = 16'd2; vb[0] = 16'd3;
    va[1] = 16'd4; vb[1] = 16'd5;
    va[2] = 16'd6; vb[2] = 16'd7;
    run_op(3, 0, 0, 1'b0);
    run_op(3, 2, 2, 1'b0);

    // Empty vector
    run_op(0, 0, 0, 1'b0);

    // Accumulator wrap
    va[0] = 16'hFFFF; vb[0] = 16'hFFFF;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF;
    run_op(2, 0, 1, 1'b0);

    // Result held in DONE while start pulses
    va[0] = 16'd10; vb[0] = 16'd11;
    run_op(1, 0, 0, 1'b1);

    // Reset after one of three pairs, then a fresh operation
    va[0] = 16'd5; vb[0] = 16'd6;
    va[1] = 16'd7; vb[1] = 16'd8;
    va[2] = 16'd9; vb[2] = 16'd10;
    wait_idle();
    start = 1'b1;
    len   = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    feed_pair(0, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_res_valid", 64'(res_valid), 64'd0);
    check("abort_acc", 64'(res_data), 64'd0);
    check("abort_ovf", 64'(res_ovf), 64'd0);
    va[0] = 16'd3; vb[0] = 16'd3;
    run_op(1, 0, 0, 1'b0);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      int n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        va[i] = ($urandom_range(0, 2) == 0) ? (16'hFF00 | 16'($urandom)) : 16'($urandom);
        vb[i] = ($urandom_range(0, 2) == 0) ? (16'hFF00 | 16'($urandom)) : 16'($urandom);
      end
      run_op(n, 0, 3, 1'($urandom_range(0, 5) == 0));
    end

    wait_idle();
    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin
        @(posedge clk);
        t++;
      end
    end
    check("results_drained", 64'(exp_q.size()), 64'd0);
    check("latencies_drained", 64'(vcyc_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
